// File: rtl/ccff_chain_loader.sv
// -----------------------------------------------------------------------------
// ccff_chain_loader
//
// Writer end of the configuration-chain protocol. Bytes arrive on a
// valid/ready handshake and are serialised LSB-first onto ccff_head while
// shift_en qualifies the chain flops on prog_clk. In verify mode the host
// sends the bitstream twice; during the second pass every bit emerging on
// ccff_tail is compared with the bit being sent, and any difference sets a
// sticky error flag.
//
// Ports:
//   prog_clk      programming clock, all state updates on its rising edge
//   prog_reset_n  asynchronous active-low reset
//   start         one-cycle pulse, begins a load when idle
//   verify        sampled with start, 1 = two-pass load with readback compare
//   abort         returns the block to IDLE at the next edge
//   data_in       bitstream byte, bit 0 shifted first
//   data_valid    data_in is valid
//   data_ready    block accepts data_in this cycle
//   ccff_head     serial configuration bit to the chain
//   shift_en      chain captures ccff_head on this prog_clk edge
//   ccff_tail     serial output of the last chain flop
//   busy          a load is in progress
//   done          one-cycle pulse when a load completes
//   error         sticky readback mismatch, cleared by start
//   bit_count     bits shifted in the current pass
// -----------------------------------------------------------------------------
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 31,
    parameter int CNT_W     = 16
) (
    input  logic             prog_clk,
    input  logic             prog_reset_n,
    input  logic             start,
    input  logic             verify,
    input  logic             abort,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ccff_head,
    output logic             shift_en,
    input  logic             ccff_tail,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_CHAIN_LEN = CNT_W'(CHAIN_LEN);

    state_t           r_state;
    state_t           w_nextState;
    logic [7:0]       r_shreg;
    logic [3:0]       r_nbits;
    logic [CNT_W-1:0] r_bitCount;
    logic             r_pass;
    logic             r_verify;
    logic             r_error;

    logic [CNT_W-1:0] w_remaining;
    logic [3:0]       w_fetchBits;
    logic [CNT_W-1:0] w_bitCountInc;
    logic             w_lastBit;
    logic             w_passEnd;
    logic             w_needSecondPass;

    // The final byte of a pass only contributes the bits still missing, so
    // the shift count per pass always lands exactly on CHAIN_LEN.
    assign w_remaining      = LP_CHAIN_LEN - r_bitCount;
    assign w_fetchBits      = (w_remaining >= CNT_W'(8)) ? 4'd8 : w_remaining[3:0];
    assign w_bitCountInc    = r_bitCount + CNT_W'(1);
    assign w_lastBit        = (r_nbits == 4'd1);
    assign w_passEnd        = (w_bitCountInc >= LP_CHAIN_LEN);
    assign w_needSecondPass = r_verify && !r_pass;

    // State register
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        w_nextState = r_state;
        if (abort) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_nextState = FETCH;
                    end
                end
                FETCH: begin
                    if (data_valid) begin
                        w_nextState = SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_lastBit) begin
                        if (!w_passEnd || w_needSecondPass) begin
                            w_nextState = FETCH;
                        end else begin
                            w_nextState = DONE;
                        end
                    end
                end
                DONE: begin
                    w_nextState = IDLE;
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        data_ready = (r_state == FETCH);
        shift_en   = (r_state == SHIFT);
        ccff_head  = (r_state == SHIFT) && r_shreg[0];
        busy       = (r_state == FETCH) || (r_state == SHIFT);
        done       = (r_state == DONE);
        error      = r_error;
    end

    assign bit_count = r_bitCount;

    // Datapath. An aborted cycle leaves every register untouched, so error
    // keeps whatever the interrupted load had found.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_shreg    <= 8'd0;
            r_nbits    <= 4'd0;
            r_bitCount <= '0;
            r_pass     <= 1'b0;
            r_verify   <= 1'b0;
            r_error    <= 1'b0;
        end else if (!abort) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_error    <= 1'b0;
                        r_bitCount <= '0;
                        r_verify   <= verify;
                        r_pass     <= 1'b0;
                    end
                end
                FETCH: begin
                    if (data_valid) begin
                        r_shreg <= data_in;
                        r_nbits <= w_fetchBits;
                    end
                end
                SHIFT: begin
                    r_shreg <= {1'b0, r_shreg[7:1]};
                    r_nbits <= r_nbits - 4'd1;
                    // After a full first pass the chain is primed, so the bit
                    // leaving ccff_tail is the same-index bit of pass one.
                    if (r_verify && r_pass && (ccff_tail != r_shreg[0])) begin
                        r_error <= 1'b1;
                    end
                    if (w_lastBit && w_passEnd && w_needSecondPass) begin
                        r_pass     <= 1'b1;
                        r_bitCount <= '0;
                    end else begin
                        r_bitCount <= w_bitCountInc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Writer end of the configuration-chain protocol. Takes a bitstream as bytes over a valid/ready handshake and serialises it onto ccff_head of a routing-tile configuration chain.
- Drives a shift-enable that a clock-gate cell uses to qualify the chain's flops on prog_clk.
- In verify mode, the host sends the bitstream twice. During the second pass the block compares the chain's ccff_tail against the bits being sent and flags any mismatch.
- Sits between the programming host interface and the first tile's ccff_head. The last tile's ccff_tail returns to this block.

Parameters:
CHAIN_LEN, 31, number of configuration flops in the chain (bits per pass); must be >= 1
CNT_W, 16, width of the bit counter; 2^CNT_W must be > CHAIN_LEN

Ports:
prog_clk  input  1  programming clock; all state is updated on its rising edge
prog_reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load when idle
verify  input  1  sampled with start; 1 = two-pass load plus readback compare
abort  input  1  returns the block to IDLE at the next edge
data_in  input  8  bitstream byte; bit 0 is shifted first
data_valid  input  1  data_in is valid
data_ready  output  1  block accepts data_in this cycle
ccff_head  output  1  serial configuration bit to the chain
shift_en  output  1  the chain captures ccff_head on this prog_clk edge
ccff_tail  input  1  serial output of the last chain flop
busy  output  1  a load is in progress
done  output  1  one-cycle pulse when a load completes
error  output  1  sticky readback mismatch; cleared by start
bit_count  output  CNT_W  bits shifted in the current pass

Behaviour:
- Reset values: all outputs 0; state IDLE; shift register, bit_count, pass and error cleared. Reset may assert at any time, including mid-operation, with immediate effect.
- States are IDLE, FETCH, SHIFT and DONE.
- IDLE:
  - start=1 clears error and bit_count, latches verify, sets pass=0 and moves to FETCH.
  - start is ignored outside IDLE.
- FETCH:
  - data_ready=1, combinationally from state.
  - On data_valid=1, load data_in into the 8-bit shift register, set nbits=min(8, CHAIN_LEN-bit_count) and move to SHIFT.
  - While data_valid=0, stay in FETCH.
- SHIFT:
  - shift_en=1 and ccff_head=shreg[0], both decoded from registered state.
  - Each cycle: shift shreg right by one, increment bit_count, decrement nbits.
  - Compare: when latched verify=1 and pass=1, if ccff_tail != ccff_head at the edge, set error. The first bit in emerges first after CHAIN_LEN shifts, so no bit buffer is needed.
- Leaving SHIFT, after the cycle in which nbits reaches 0:
  - If bit_count < CHAIN_LEN, go to FETCH.
  - Else, if verify=1 and pass=0, set pass=1, clear bit_count and go to FETCH.
  - Else go to DONE.
- Partial last byte: unused upper bits of the final byte of each pass are discarded. Each pass starts on a fresh byte, so bytes per pass = ceil(CHAIN_LEN/8).
- DONE: done=1 for one cycle, then IDLE. busy=1 in FETCH and SHIFT. bit_count holds its final value in IDLE.
- abort has priority over every transition except reset:
  - next state IDLE; shift_en=0 from the next cycle; done is not pulsed; error retains its value.
- Rate: one byte costs 1 FETCH cycle plus nbits SHIFT cycles when data_valid is held high.
- shift_en is never 1 outside SHIFT. The number of shift_en cycles per pass equals CHAIN_LEN exactly.

Test Plan:
- Reset, then hold data_valid=0 -> all outputs 0. After start, data_ready=1, no shift_en, busy=1.
- CHAIN_LEN=31, verify=0, bytes 0xA5,0x3C,0xFF,0x7E -> exactly 31 shift_en cycles; ccff_head sequence is LSB-first 1,0,1,0,0,1,0,1,…; bit 7 of 0x7E is never shifted; done pulses once; bit_count=31.
- verify=1, same 4 bytes twice, behavioural 31-bit shift-register chain model -> 62 shift_en cycles; error=0 at done.
- verify=1, second pass with byte 1 changed to 0x3D -> error=1 from the shift of bit 8; done still pulses; the next start clears error.
- Drop data_valid for 5 cycles between bytes -> the block stalls in FETCH with shift_en=0; the ccff_head sequence is unchanged.
- abort during SHIFT at bit 12 -> IDLE next cycle, no done, busy=0. Repeat the test with prog_reset_n asserted mid-SHIFT -> all outputs 0 asynchronously.
